// File: rtl/gige_rx_pack.sv
// Receive packer: folds a byte-wide GMII stream into 64-bit XGMII-style words
// (/S/ data /E/ /T/ idle pad) plus one byte-count entry per frame.
module gige_rx_pack #(
   parameter int unsigned MAX_BYTES = 1600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mode_1G,
   input  logic        rx_en,
   input  logic [7:0]  rxd,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic        data_fifo_afull,
   input  logic        bcnt_fifo_full,
   output logic        gige_data_fifo_we,
   output logic [63:0] gige_data_fifo_wdata,
   output logic [7:0]  gige_data_fifo_wctrl,
   output logic        gige_bcnt_fifo_we,
   output logic [15:0] gige_bcnt_fifo_wdata,
   output logic        frame_drop
);

   typedef enum logic [2:0] {StIdle, StPack, StTerm, StBcnt, StDiscard} state_e;

   localparam logic [14:0] TruncAt = 15'(MAX_BYTES - 2);
   localparam logic [7:0]  CharS   = 8'hFB;
   localparam logic [7:0]  CharT   = 8'hFD;
   localparam logic [7:0]  CharE   = 8'hFE;
   localparam logic [7:0]  CharI   = 8'h07;

   state_e      state;
   logic [2:0]  lane;
   logic [14:0] bcnt;
   logic [63:0] word;
   logic [7:0]  word_ctrl;
   logic        trunc;
   logic        prev_dv;

   logic        ins_err;
   logic [63:0] word_ins;
   logic [7:0]  ctrl_ins;
   logic [63:0] term_word;
   logic [7:0]  term_ctrl;
   logic        dv_now;

   always_comb begin
      // The byte that would push bcnt to MAX_BYTES-1 is replaced by /E/.
      ins_err  = rx_er | (bcnt == TruncAt);
      word_ins = word;
      ctrl_ins = word_ctrl;
      word_ins[{lane, 3'b000} +: 8] = ins_err ? CharE : rxd;
      ctrl_ins[lane] = ins_err;

      term_word = word;
      term_ctrl = word_ctrl;
      for (int i = 0; i < 8; i++) begin
         if (3'(i) == lane) begin
            term_word[i*8 +: 8] = CharT;
            term_ctrl[i]        = 1'b1;
         end else if (3'(i) > lane) begin
            term_word[i*8 +: 8] = CharI;
            term_ctrl[i]        = 1'b1;
         end
      end

      dv_now = rx_en ? rx_dv : prev_dv;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= StIdle;
         lane                 <= 3'd0;
         bcnt                 <= 15'd0;
         word                 <= {8{CharI}};
         word_ctrl            <= 8'hFF;
         trunc                <= 1'b0;
         // Treat the line as mid-frame until a low rx_dv byte is seen.
         prev_dv              <= 1'b1;
         gige_data_fifo_we    <= 1'b0;
         gige_data_fifo_wdata <= {8{CharI}};
         gige_data_fifo_wctrl <= 8'hFF;
         gige_bcnt_fifo_we    <= 1'b0;
         gige_bcnt_fifo_wdata <= 16'd0;
         frame_drop           <= 1'b0;
      end else begin
         gige_data_fifo_we <= 1'b0;
         gige_bcnt_fifo_we <= 1'b0;
         frame_drop        <= 1'b0;
         if (rx_en) begin
            prev_dv <= rx_dv;
         end

         unique case (state)
            StIdle: begin
               if (rx_en && rx_dv) begin
                  if (mode_1G && !prev_dv && !data_fifo_afull && !bcnt_fifo_full) begin
                     word[7:0]    <= CharS;
                     word_ctrl[0] <= 1'b1;
                     lane         <= 3'd1;
                     bcnt         <= 15'd1;
                     trunc        <= 1'b0;
                     state        <= StPack;
                  end else begin
                     frame_drop <= 1'b1;
                     state      <= StDiscard;
                  end
               end
            end

            StPack: begin
               if (rx_en) begin
                  if (rx_dv) begin
                     word      <= word_ins;
                     word_ctrl <= ctrl_ins;
                     lane      <= lane + 3'd1;
                     bcnt      <= bcnt + 15'd1;
                     if (lane == 3'd7) begin
                        gige_data_fifo_we    <= 1'b1;
                        gige_data_fifo_wdata <= word_ins;
                        gige_data_fifo_wctrl <= ctrl_ins;
                     end
                     if (bcnt == TruncAt) begin
                        trunc <= 1'b1;
                        state <= StTerm;
                     end
                  end else begin
                     state <= StTerm;
                  end
               end
            end

            // /T/ always lands here, so bcnt counts it in this state.
            StTerm: begin
               gige_data_fifo_we    <= 1'b1;
               gige_data_fifo_wdata <= term_word;
               gige_data_fifo_wctrl <= term_ctrl;
               bcnt                 <= bcnt + 15'd1;
               state                <= StBcnt;
            end

            StBcnt: begin
               gige_bcnt_fifo_we    <= 1'b1;
               gige_bcnt_fifo_wdata <= {1'b0, bcnt};
               lane                 <= 3'd0;
               state                <= (trunc && dv_now) ? StDiscard : StIdle;
            end

            StDiscard: begin
               if (rx_en && !rx_dv) begin
                  state <= StIdle;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gige_rx_pack.sv
// Self-checking bench for gige_rx_pack: random frames against a byte-stream reference
// model, plus fixed-pattern checks for the headline cases.
module tb_gige_rx_pack;

   localparam int MaxBytes = 1600;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode_1G;
   logic        rx_en;
   logic [7:0]  rxd;
   logic        rx_dv;
   logic        rx_er;
   logic        data_fifo_afull;
   logic        bcnt_fifo_full;
   logic        gige_data_fifo_we;
   logic [63:0] gige_data_fifo_wdata;
   logic [7:0]  gige_data_fifo_wctrl;
   logic        gige_bcnt_fifo_we;
   logic [15:0] gige_bcnt_fifo_wdata;
   logic        frame_drop;

   gige_rx_pack #(.MAX_BYTES(MaxBytes)) dut (
      .clk                  (clk),
      .reset                (reset),
      .mode_1G              (mode_1G),
      .rx_en                (rx_en),
      .rxd                  (rxd),
      .rx_dv                (rx_dv),
      .rx_er                (rx_er),
      .data_fifo_afull      (data_fifo_afull),
      .bcnt_fifo_full       (bcnt_fifo_full),
      .gige_data_fifo_we    (gige_data_fifo_we),
      .gige_data_fifo_wdata (gige_data_fifo_wdata),
      .gige_data_fifo_wctrl (gige_data_fifo_wctrl),
      .gige_bcnt_fifo_we    (gige_bcnt_fifo_we),
      .gige_bcnt_fifo_wdata (gige_bcnt_fifo_wdata),
      .frame_drop           (frame_drop)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Captured DUT writes
   int          cyc = 0;
   logic [63:0] got_w[$];
   logic [7:0]  got_c[$];
   logic [15:0] got_b[$];
   int          got_nw[$];
   int          got_gap[$];
   int          drops = 0;
   int          last_dcyc = 0;
   int          words_since = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) words_since = 0;
      if (gige_data_fifo_we) begin
         got_w.push_back(gige_data_fifo_wdata);
         got_c.push_back(gige_data_fifo_wctrl);
         last_dcyc = cyc;
         words_since++;
      end
      if (gige_bcnt_fifo_we) begin
         got_b.push_back(gige_bcnt_fifo_wdata);
         got_nw.push_back(words_since);
         got_gap.push_back(cyc - last_dcyc);
         words_since = 0;
      end
      if (frame_drop) drops++;
   end

   // Reference model state
   logic [7:0]  frm[$];
   logic [63:0] exp_w[$];
   logic [7:0]  exp_c[$];
   logic [15:0] exp_b[$];
   int          exp_nw[$];

   function automatic void gen_frame(input int n);
      frm.delete();
      for (int i = 0; i < n; i++) begin
         if (i < 7) frm.push_back(8'h55);
         else if (i == 7) frm.push_back(8'hD5);
         else frm.push_back(8'($urandom));
      end
   endfunction

   function automatic void clear_exp();
      exp_w.delete();
      exp_c.delete();
      exp_b.delete();
      exp_nw.delete();
   endfunction

   // Builds the on-wire lane sequence {ctrl, byte} for the frame, then slices it into words.
   function automatic void model_frame(input int err_at);
      logic [8:0]  s[$];
      logic [63:0] d;
      logic [7:0]  c;
      s.push_back({1'b1, 8'hFB});
      for (int i = 1; i < frm.size(); i++) begin
         if (s.size() == MaxBytes - 2) begin
            s.push_back({1'b1, 8'hFE});
            break;
         end
         if (i == err_at) s.push_back({1'b1, 8'hFE});
         else s.push_back({1'b0, frm[i]});
      end
      s.push_back({1'b1, 8'hFD});
      exp_b.push_back(16'(s.size()));
      exp_nw.push_back((s.size() + 7) / 8);
      while (s.size() % 8 != 0) s.push_back({1'b1, 8'h07});
      for (int w = 0; w < s.size() / 8; w++) begin
         for (int l = 0; l < 8; l++) begin
            d[l*8 +: 8] = s[w*8 + l][7:0];
            c[l]        = s[w*8 + l][8];
         end
         exp_w.push_back(d);
         exp_c.push_back(c);
      end
   endfunction

   task automatic drive_byte(input logic dv, input logic er, input logic [7:0] d, input int duty);
      repeat (duty - 1) begin
         rx_en = 1'b0;
         rx_dv = 1'($urandom);
         rx_er = 1'($urandom);
         rxd   = 8'($urandom);
         @(posedge clk);
         #1;
      end
      rx_en = 1'b1;
      rx_dv = dv;
      rx_er = er;
      rxd   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle(input int k, input int duty);
      for (int i = 0; i < k; i++) drive_byte(1'b0, 1'b0, 8'($urandom), duty);
   endtask

   task automatic send_frame(input int err_at, input int duty, input int afull_at);
      for (int i = 0; i < frm.size(); i++) begin
         if (i == afull_at) data_fifo_afull = 1'b1;
         drive_byte(1'b1, (i == err_at), frm[i], duty);
      end
      data_fifo_afull = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (gige_data_fifo_we !== 1'b0 || gige_bcnt_fifo_we !== 1'b0 || frame_drop !== 1'b0) begin
         bad++;
         $display("FAIL reset strobes: got %b%b%b want 000", gige_data_fifo_we,
                  gige_bcnt_fifo_we, frame_drop);
      end
      total++;
      if (gige_data_fifo_wdata !== 64'h0707070707070707) begin
         bad++;
         $display("FAIL reset wdata: got %h want 0707070707070707", gige_data_fifo_wdata);
      end
      total++;
      if (gige_data_fifo_wctrl !== 8'hFF) begin
         bad++;
         $display("FAIL reset wctrl: got %h want ff", gige_data_fifo_wctrl);
      end
      total++;
      if (gige_bcnt_fifo_wdata !== 16'h0000) begin
         bad++;
         $display("FAIL reset bcnt wdata: got %h want 0000", gige_bcnt_fifo_wdata);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive_idle(4, 1);
   endtask

   task automatic test_basic();
      int bw = got_w.size();
      int bb = got_b.size();
      clear_exp();
      gen_frame(72);
      for (int i = 8; i < 72; i++) frm[i] = 8'(i);
      model_frame(-1);
      send_frame(-1, 1, -1);
      drive_idle(5, 1);
      gen_frame(75);
      model_frame(-1);
      send_frame(-1, 1, -1);
      drive_idle(5, 1);
      total++;
      if (got_w.size() - bw !== 20 || got_b.size() - bb !== 2) begin
         bad++;
         $display("FAIL basic counts: got %0d words %0d bcnt want 20 words 2 bcnt",
                  got_w.size() - bw, got_b.size() - bb);
      end else begin
         total++;
         if (got_w[bw] !== 64'hD5555555555555FB || got_c[bw] !== 8'h01) begin
            bad++;
            $display("FAIL basic word0: got %h/%h want D5555555555555FB/01", got_w[bw], got_c[bw]);
         end
         total++;
         if (got_w[bw+9] !== 64'h07070707070707FD || got_c[bw+9] !== 8'hFF) begin
            bad++;
            $display("FAIL basic 72 last: got %h/%h want 07070707070707FD/ff", got_w[bw+9],
                     got_c[bw+9]);
         end
         total++;
         if (got_b[bb] !== 16'h0049 || got_b[bb+1] !== 16'h004C) begin
            bad++;
            $display("FAIL basic bcnt: got %h,%h want 0049,004c", got_b[bb], got_b[bb+1]);
         end
         total++;
         if (got_c[bw+19] !== 8'hF8 || got_w[bw+19][63:24] !== 40'h07070707FD) begin
            bad++;
            $display("FAIL basic 75 last: got %h/%h want 07070707FD....../f8", got_w[bw+19],
                     got_c[bw+19]);
         end
      end
      for (int i = 0; i < exp_w.size() && bw + i < got_w.size(); i++) begin
         total++;
         if ({got_c[bw+i], got_w[bw+i]} !== {exp_c[i], exp_w[i]}) begin
            bad++;
            $display("FAIL basic word %0d: got %h/%h want %h/%h", i, got_c[bw+i], got_w[bw+i],
                     exp_c[i], exp_w[i]);
         end
      end
      for (int i = 0; i < exp_b.size() && bb + i < got_b.size(); i++) begin
         total++;
         if (got_b[bb+i] !== exp_b[i] || got_nw[bb+i] !== exp_nw[i] || got_gap[bb+i] !== 1) begin
            bad++;
            $display("FAIL basic bcnt %0d: got %h/%0dw/gap%0d want %h/%0dw/gap1", i, got_b[bb+i],
                     got_nw[bb+i], got_gap[bb+i], exp_b[i], exp_nw[i]);
         end
      end
   endtask

   task automatic test_rx_error();
      int bw = got_w.size();
      int bb = got_b.size();
      gen_frame(72);
      send_frame(19, 1, -1);
      drive_idle(5, 1);
      total++;
      if (got_w.size() - bw !== 10 || got_b.size() - bb !== 1) begin
         bad++;
         $display("FAIL rx_error counts: got %0d words %0d bcnt want 10 1", got_w.size() - bw,
                  got_b.size() - bb);
      end else begin
         total++;
         if (got_w[bw+2][31:24] !== 8'hFE || got_c[bw+2] !== 8'h08) begin
            bad++;
            $display("FAIL rx_error lane: got %h/%h want lane3 fe ctrl 08", got_w[bw+2],
                     got_c[bw+2]);
         end
         total++;
         if (got_b[bb] !== 16'h0049) begin
            bad++;
            $display("FAIL rx_error bcnt: got %h want 0049", got_b[bb]);
         end
      end
   endtask

   task automatic test_flow_drop();
      int bw = got_w.size();
      int bb = got_b.size();
      int bd = drops;
      gen_frame(72);
      data_fifo_afull = 1'b1;
      for (int i = 0; i < 72; i++) drive_byte(1'b1, 1'b0, frm[i], 1);
      data_fifo_afull = 1'b0;
      drive_idle(5, 1);
      bcnt_fifo_full = 1'b1;
      send_frame(-1, 1, -1);
      bcnt_fifo_full = 1'b0;
      drive_idle(5, 1);
      mode_1G = 1'b0;
      send_frame(-1, 1, -1);
      drive_idle(5, 1);
      total++;
      if (got_w.size() - bw !== 0 || got_b.size() - bb !== 0 || drops - bd !== 3) begin
         bad++;
         $display("FAIL flow drop: got %0d words %0d bcnt %0d drops want 0 0 3",
                  got_w.size() - bw, got_b.size() - bb, drops - bd);
      end
      // Good frame; afull rising mid-frame must be ignored, mode_1G flips mid-frame too.
      mode_1G = 1'b1;
      bw = got_w.size();
      bb = got_b.size();
      clear_exp();
      gen_frame(40 + int'($urandom_range(0, 60)));
      model_frame(-1);
      for (int i = 0; i < frm.size(); i++) begin
         if (i == 12) data_fifo_afull = 1'b1;
         if (i == 15) mode_1G = 1'b0;
         drive_byte(1'b1, 1'b0, frm[i], 1);
      end
      data_fifo_afull = 1'b0;
      mode_1G = 1'b1;
      drive_idle(5, 1);
      total++;
      if (got_w.size() - bw !== exp_w.size() || got_b.size() - bb !== 1) begin
         bad++;
         $display("FAIL flow resume counts: got %0d words want %0d", got_w.size() - bw,
                  exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && bw + i < got_w.size(); i++) begin
         total++;
         if ({got_c[bw+i], got_w[bw+i]} !== {exp_c[i], exp_w[i]}) begin
            bad++;
            $display("FAIL flow resume word %0d: got %h/%h want %h/%h", i, got_c[bw+i],
                     got_w[bw+i], exp_c[i], exp_w[i]);
         end
      end
      if (got_b.size() > bb) begin
         total++;
         if (got_b[bb] !== exp_b[0]) begin
            bad++;
            $display("FAIL flow resume bcnt: got %h want %h", got_b[bb], exp_b[0]);
         end
      end
   endtask

   task automatic test_truncation();
      int bw = got_w.size();
      int bb = got_b.size();
      clear_exp();
      gen_frame(2000);
      model_frame(-1);
      send_frame(-1, 1, -1);
      drive_idle(6, 1);
      total++;
      if (got_w.size() - bw !== 200 || got_b.size() - bb !== 1) begin
         bad++;
         $display("FAIL trunc counts: got %0d words %0d bcnt want 200 1", got_w.size() - bw,
                  got_b.size() - bb);
      end else begin
         total++;
         if (got_b[bb] !== 16'h0640) begin
            bad++;
            $display("FAIL trunc bcnt: got %h want 0640", got_b[bb]);
         end
         total++;
         if (got_w[bw+199][63:48] !== 16'hFDFE || got_c[bw+199][7:6] !== 2'b11) begin
            bad++;
            $display("FAIL trunc tail: got %h/%h want FDFE at lanes 7:6", got_w[bw+199],
                     got_c[bw+199]);
         end
      end
      for (int i = 0; i < exp_w.size() && bw + i < got_w.size(); i++) begin
         total++;
         if ({got_c[bw+i], got_w[bw+i]} !== {exp_c[i], exp_w[i]}) begin
            bad++;
            $display("FAIL trunc word %0d: got %h/%h want %h/%h", i, got_c[bw+i], got_w[bw+i],
                     exp_c[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bw = got_w.size();
      int bb = got_b.size();
      int err;
      clear_exp();
      for (int f = 0; f < 3; f++) begin
         gen_frame(int'($urandom_range(20, 100)));
         err = ($urandom_range(0, 1) == 1) ? int'($urandom_range(8, 19)) : -1;
         model_frame(err);
         send_frame(err, 1, -1);
         drive_idle(3, 1);
      end
      drive_idle(4, 1);
      total++;
      if (got_w.size() - bw !== exp_w.size() || got_b.size() - bb !== exp_b.size()) begin
         bad++;
         $display("FAIL b2b counts: got %0d/%0d want %0d/%0d", got_w.size() - bw,
                  got_b.size() - bb, exp_w.size(), exp_b.size());
      end
      for (int i = 0; i < exp_w.size() && bw + i < got_w.size(); i++) begin
         total++;
         if ({got_c[bw+i], got_w[bw+i]} !== {exp_c[i], exp_w[i]}) begin
            bad++;
            $display("FAIL b2b word %0d: got %h/%h want %h/%h", i, got_c[bw+i], got_w[bw+i],
                     exp_c[i], exp_w[i]);
         end
      end
      for (int i = 0; i < exp_b.size() && bb + i < got_b.size(); i++) begin
         total++;
         if (got_b[bb+i] !== exp_b[i] || got_nw[bb+i] !== exp_nw[i] || got_gap[bb+i] !== 1) begin
            bad++;
            $display("FAIL b2b bcnt %0d: got %h/%0dw/gap%0d want %h/%0dw/gap1", i, got_b[bb+i],
                     got_nw[bb+i], got_gap[bb+i], exp_b[i], exp_nw[i]);
         end
      end
   endtask

   task automatic test_duty_reset();
      int bw;
      int bb;
      // Partial frame at 1/8 duty, then reset: nothing more may be written for it.
      gen_frame(60);
      for (int i = 0; i < 20; i++) drive_byte(1'b1, 1'b0, frm[i], 8);
      reset = 1'b1;
      rx_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bw = got_w.size();
      bb = got_b.size();
      for (int i = 20; i < 60; i++) drive_byte(1'b1, 1'b0, frm[i], 8);
      drive_idle(3, 8);
      total++;
      if (got_w.size() - bw !== 0 || got_b.size() - bb !== 0) begin
         bad++;
         $display("FAIL reset midframe: got %0d words %0d bcnt want 0 0", got_w.size() - bw,
                  got_b.size() - bb);
      end
      clear_exp();
      for (int f = 0; f < 2; f++) begin
         gen_frame(int'($urandom_range(30, 90)));
         model_frame(-1);
         send_frame(-1, 8, -1);
         drive_idle(3, 8);
      end
      total++;
      if (got_w.size() - bw !== exp_w.size() || got_b.size() - bb !== exp_b.size()) begin
         bad++;
         $display("FAIL duty counts: got %0d/%0d want %0d/%0d", got_w.size() - bw,
                  got_b.size() - bb, exp_w.size(), exp_b.size());
      end
      for (int i = 0; i < exp_w.size() && bw + i < got_w.size(); i++) begin
         total++;
         if ({got_c[bw+i], got_w[bw+i]} !== {exp_c[i], exp_w[i]}) begin
            bad++;
            $display("FAIL duty word %0d: got %h/%h want %h/%h", i, got_c[bw+i], got_w[bw+i],
                     exp_c[i], exp_w[i]);
         end
      end
      for (int i = 0; i < exp_b.size() && bb + i < got_b.size(); i++) begin
         total++;
         if (got_b[bb+i] !== exp_b[i] || got_nw[bb+i] !== exp_nw[i]) begin
            bad++;
            $display("FAIL duty bcnt %0d: got %h/%0dw want %h/%0dw", i, got_b[bb+i],
                     got_nw[bb+i], exp_b[i], exp_nw[i]);
         end
      end
   endtask

   initial begin
      reset           = 1'b1;
      mode_1G         = 1'b1;
      rx_en           = 1'b0;
      rxd             = 8'h00;
      rx_dv           = 1'b0;
      rx_er           = 1'b0;
      data_fifo_afull = 1'b0;
      bcnt_fifo_full  = 1'b0;
      test_reset();
      test_basic();
      test_rx_error();
      test_flow_drop();
      test_truncation();
      test_back_to_back();
      test_duty_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gige_rx_pack.md
# gige_rx_pack

Receive-side packer for 1G operation. Takes the byte-wide GMII receive stream (rxd/rx_dv/rx_er with a byte-enable strobe) and packs each frame into 64-bit XGMII-style words (/S/, data, /E/, /T/, idle pad). Each frame's words go into gige_rx_data_fifo, and one byte-count entry per frame goes into gige_rx_bcnt_fifo. It sits directly upstream of the 1G-to-XGMII read controller, which drains both FIFOs using the bcnt entry to size each frame.

## Interface
Parameters:
- MAX_BYTES, 1600: maximum bcnt per frame, counting /S/, preamble, SFD, data and /T/. Legal range 16..32767.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- mode_1G  in  1  block enabled; sampled only in IDLE.
- rx_en  in  1  byte strobe; rxd/rx_dv/rx_er are valid only when rx_en=1.
- rxd  in  8  GMII receive byte.
- rx_dv  in  1  GMII data valid.
- rx_er  in  1  GMII receive error.
- data_fifo_afull  in  1  data FIFO almost full; asserted with at least ceil(MAX_BYTES/8) words of headroom.
- bcnt_fifo_full  in  1  bcnt FIFO full.
- gige_data_fifo_we  out  1  data FIFO write strobe.
- gige_data_fifo_wdata  out  64  packed word; lane n = [8n+7:8n].
- gige_data_fifo_wctrl  out  8  per-lane control flag; bit n goes with lane n.
- gige_bcnt_fifo_we  out  1  bcnt FIFO write strobe.
- gige_bcnt_fifo_wdata  out  16  [15] sof4 flag, always 0; [14:0] byte count.
- frame_drop  out  1  one-cycle pulse for each frame discarded.

## Operation
- States: IDLE, PACK, TERM, BCNT, DISCARD. Only bytes with rx_en=1 are processed.
- IDLE: on rx_en & rx_dv:
  - If mode_1G & !data_fifo_afull & !bcnt_fifo_full: enter PACK and write lane0 = 0xFB with ctrl=1. This /S/ replaces the first preamble byte. Set bcnt = 1.
  - Otherwise: pulse frame_drop and enter DISCARD.
- PACK, on each rx_en & rx_dv byte:
  - If rx_er=1: lane byte = 0xFE, ctrl=1.
  - Else: lane byte = rxd, ctrl=0.
  - Advance lane and bcnt by 1.
  - When lane 7 is filled, write the word and wrap the lane to 0.
- PACK, on rx_en & !rx_dv: place 0xFD (ctrl=1) in the current lane, bcnt += 1, go to TERM.
- Truncation: if a byte arrives in PACK while bcnt == MAX_BYTES-2:
  - Write 0xFE (ctrl=1) in place of that byte, bcnt += 1.
  - Go to TERM; /T/ is placed there and bcnt reaches MAX_BYTES.
  - After BCNT, go to DISCARD instead of IDLE if rx_dv is still high.
- Lane fill: in TERM, every lane above the last filled lane gets 0x07 with ctrl=1.
  - If /T/ falls on lane 0 of a fresh word, the word is FD + seven 07 bytes, ctrl 0xFF.
- TERM: write the final word (gige_data_fifo_we=1), then go to BCNT.
- BCNT: gige_bcnt_fifo_we=1 with {1'b0, bcnt[14:0]}, then go to IDLE (or DISCARD, as above).
- Byte-count rules:
  - bcnt excludes pad lanes.
  - Words written per frame = ceil(bcnt/8).
  - The byte counter is 15 bits and never wraps, because it is capped by MAX_BYTES.
- DISCARD: no FIFO writes; return to IDLE on rx_en & !rx_dv.
- mode_1G=0 in IDLE: no writes at all. Changes to mode_1G during a frame are ignored.

## Timing
- Reset values:
  - FIFO write strobes 0; frame_drop 0.
  - wdata 0x0707070707070707, wctrl 0xFF, bcnt wdata 0.
  - State IDLE, lane 0, bcnt 0.
- A full word is registered out on the clk after the rx_en cycle that filled lane 7.
- The final word is written 1 clk after /T/ is detected.
- The bcnt entry is written exactly 1 clk after the final data word. It never precedes any of its frame's data words.
- TERM and BCNT ignore rx inputs. With rx_en held high, an rx_dv rise is first seen in IDLE 2 clks after the falling edge.
  - A frame whose rx_dv rises during TERM/BCNT is not started until the next rising edge seen in IDLE.
  - Its remaining bytes are treated as DISCARD, and frame_drop is pulsed.
- Flow control: afull/full are sampled only at frame start. Mid-frame changes are ignored, since headroom is guaranteed by the afull threshold.
- Reset mid-frame: state returns to IDLE immediately. No partial word or bcnt is written. Bytes of the in-progress frame are discarded until rx_dv goes low.

## Test plan
- 72-byte rx_dv burst (7×0x55, 0xD5, 64 data), rx_en=1 → 10 data writes, then one bcnt write:
  - word0 = D5_55_55_55_55_55_55_FB, ctrl 0x01.
  - 8 data words, ctrl 0x00.
  - Last word = 0707070707070_7FD, ctrl 0xFF.
  - bcnt = 0x0049.
- 75-byte burst → bcnt 0x004C; last word lanes 0-2 data, lane3 = FD, lanes 4-7 = 07, ctrl 0xF8; 10 words.
- rx_er on the 20th byte → lane 3 of word2 = 0xFE with ctrl bit 3 set; bcnt unchanged versus the error-free frame.
- data_fifo_afull=1 at rx_dv rise → zero FIFO writes, one frame_drop pulse; the next frame with afull=0 is packed normally.
- 2000-byte burst with MAX_BYTES=1600 → byte 1599 = FE, byte 1600 = FD, bcnt 0x0640, 200 words; the remaining bytes produce no writes.
- rx_en toggling every 8th clk (1/8 duty) plus reset asserted mid-frame → output equals the continuous-rx_en case; after reset, no writes occur until the next frame start in IDLE.
